fp29i_to_fp16: RTL and testbench

FP29I_TO_FP16 -- requirements
Module: fp29i_to_fp16

---
 rtl/fpalu_pkg.sv | 21 ++
 rtl/lzc22.sv | 14 +
 rtl/fp29i_to_fp16.sv | 160 ++++++++++++++++
 tb/tb_fp29i_to_fp16.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpalu_pkg.sv
// Shared format constants for the FP ALU: FP29i (6-bit exp, 22-bit unnormalised
// mantissa) and IEEE binary16.
package fpalu_pkg;
    localparam int FP29_EXP_W  = 6;
    localparam int FP29_MAN_W  = 22;
    localparam int FP29_BIAS   = 30;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;
    localparam int FP16_BIAS   = 15;
    localparam int LZC_W       = 5;

    localparam logic [FP16_EXP_W-1:0]             FP16_EXP_MAX  = '1;
    localparam logic [FP16_EXP_W+FP16_FRAC_W-1:0] FP16_INF_MAG  = {FP16_EXP_MAX, {FP16_FRAC_W{1'b0}}};
    localparam logic [FP16_EXP_W+FP16_FRAC_W-1:0] FP16_ZERO_MAG = '0;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
    } fp_flags_t;
endpackage

// File: rtl/lzc22.sv
// Combinational leading-zero counter for the 22-bit FP29i mantissa; all-zero gives 22.
module lzc22
    import fpalu_pkg::*;
(
    input  logic [FP29_MAN_W-1:0] val_i,
    output logic [LZC_W-1:0]      cnt_o
);
    always_comb begin
        cnt_o = LZC_W'(FP29_MAN_W);
        // Ascending scan: the highest set bit is the last to assign.
        for (int i = 0; i < FP29_MAN_W; i++)
            if (val_i[i]) cnt_o = LZC_W'(FP29_MAN_W - 1 - i);
    end
endmodule

// File: rtl/fp29i_to_fp16.sv
// FP29i -> IEEE binary16 converter: S1 leading-zero count, S2 normalise/denormalise,
// S3 round-to-nearest-even and pack. Sticky exception flags on the output.
module fp29i_to_fp16
    import fpalu_pkg::*;
#(
    parameter int EXP_BIAS_IN  = FP29_BIAS,
    parameter int EXP_BIAS_OUT = FP16_BIAS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din_valid,
    input  logic                  din_uni_y_sgn,
    input  logic [FP29_EXP_W-1:0] din_uni_y_exp,
    input  logic [FP29_MAN_W-1:0] din_uni_y_man_dn,
    input  logic                  clr_flags,
    output logic                  dout_valid,
    output logic [15:0]           dout_fp16,
    output logic                  dout_ovf,
    output logic                  dout_unf,
    output logic                  dout_inx,
    output logic                  flg_ovf,
    output logic                  flg_unf,
    output logic                  flg_inx
);
    localparam logic signed [7:0] E_ADJ = 8'(EXP_BIAS_OUT - EXP_BIAS_IN + 1);

    logic [3:1] vld_q;

    // ---------------- S1: leading-zero count ----------------
    logic                  s1_sgn_q;
    logic [FP29_EXP_W-1:0] s1_exp_q;
    logic [FP29_MAN_W-1:0] s1_man_q;
    logic [LZC_W-1:0]      s1_lz_q;
    logic [LZC_W-1:0]      lz;

    lzc22 u_lzc (.val_i(din_uni_y_man_dn), .cnt_o(lz));

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            s1_sgn_q <= 1'b0;
            s1_exp_q <= '0;
            s1_man_q <= '0;
            s1_lz_q  <= '0;
        end else begin
            vld_q <= {vld_q[2:1], din_valid};
            if (din_valid) begin
                s1_sgn_q <= din_uni_y_sgn;
                s1_exp_q <= din_uni_y_exp;
                s1_man_q <= din_uni_y_man_dn;
                s1_lz_q  <= lz;
            end
        end
    end

    // ---------------- S2: normalise, denormalise into sticky ----------------
    logic [FP29_MAN_W-1:0] s2_norm;
    logic signed [7:0]     s2_e, s2_neg;
    logic                  s2_sub, s2_stk_d;
    logic [4:0]            s2_sh;
    logic [44:0]           s2_wide;
    logic [20:0]           s2_norm_d;

    always_comb begin
        s2_norm   = s1_man_q << s1_lz_q;
        s2_e      = $signed({2'b00, s1_exp_q}) + E_ADJ - $signed({3'b000, s1_lz_q});
        s2_sub    = (s2_e <= 8'sd0);
        s2_neg    = -s2_e;
        // Pre-shifted by one via the 23-bit pad, so a total of 1-E (max 24) needs only -E (max 23).
        s2_sh     = (s2_neg > 8'sd23) ? 5'd23 : s2_neg[4:0];
        s2_wide   = {s2_norm, 23'b0} >> s2_sh;
        s2_norm_d = s2_norm[20:0];
        s2_stk_d  = 1'b0;
        if (s2_sub) begin
            s2_norm_d = s2_wide[44:24];
            s2_stk_d  = |s2_wide[23:0];
        end
    end

    logic              s2_sgn_q, s2_zero_q, s2_sub_q, s2_stk_q;
    logic signed [7:0] s2_e_q;
    logic [20:0]       s2_norm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sgn_q  <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_sub_q  <= 1'b0;
            s2_stk_q  <= 1'b0;
            s2_e_q    <= '0;
            s2_norm_q <= '0;
        end else if (vld_q[1]) begin
            s2_sgn_q  <= s1_sgn_q;
            s2_zero_q <= (s1_lz_q == LZC_W'(FP29_MAN_W));
            s2_sub_q  <= s2_sub;
            s2_stk_q  <= s2_stk_d;
            s2_e_q    <= s2_e;
            s2_norm_q <= s2_norm_d;
        end
    end

    // ---------------- S3: round to nearest even, pack ----------------
    logic [FP16_FRAC_W-1:0] s3_frac;
    logic [FP16_EXP_W-1:0]  s3_ef;
    logic [14:0]            s3_sum;
    logic                   s3_grd, s3_stk, s3_inc, s3_ovf;
    logic [15:0]            s3_res;
    fp_flags_t              s3_flg;

    always_comb begin
        s3_frac = s2_norm_q[20:11];
        s3_grd  = s2_norm_q[10];
        s3_stk  = (|s2_norm_q[9:0]) | s2_stk_q;
        s3_inc  = s3_grd & (s3_stk | s3_frac[0]);
        s3_ef   = s2_sub_q ? '0 : s2_e_q[4:0];
        // Carry out of the fraction bumps the exponent field directly.
        s3_sum  = {s3_ef, s3_frac} + 15'(s3_inc);
        s3_ovf  = !s2_sub_q && ((s2_e_q >= 8'sd31) || (s3_sum[14:10] == FP16_EXP_MAX));
        s3_res  = {s2_sgn_q, s3_sum};
        s3_flg  = '{ovf: 1'b0, unf: s2_sub_q & (s3_grd | s3_stk), inx: s3_grd | s3_stk};
        if (s2_zero_q) begin
            s3_res = {s2_sgn_q, FP16_ZERO_MAG};
            s3_flg = '0;
        end else if (s3_ovf) begin
            s3_res = {s2_sgn_q, FP16_INF_MAG};
            s3_flg = '{ovf: 1'b1, unf: 1'b0, inx: 1'b1};
        end
    end

    logic [15:0] dout_fp16_q;
    fp_flags_t   dout_flg_q, flg_q, flg_d;

    always_comb begin
        flg_d = clr_flags ? '0 : flg_q;
        if (vld_q[3]) flg_d = flg_d | dout_flg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_fp16_q <= '0;
            dout_flg_q  <= '0;
            flg_q       <= '0;
        end else begin
            if (vld_q[2]) begin
                dout_fp16_q <= s3_res;
                dout_flg_q  <= s3_flg;
            end
            flg_q <= flg_d;
        end
    end

    assign dout_valid = vld_q[3];
    assign dout_fp16  = dout_fp16_q;
    assign dout_ovf   = dout_flg_q.ovf;
    assign dout_unf   = dout_flg_q.unf;
    assign dout_inx   = dout_flg_q.inx;
    assign flg_ovf    = flg_q.ovf;
    assign flg_unf    = flg_q.unf;
    assign flg_inx    = flg_q.inx;
endmodule

// File: tb/tb_fp29i_to_fp16.sv
// Directed bench for fp29i_to_fp16: latency, rounding, overflow, subnormals, zero,
// sticky flags and mid-stream reset.
module tb_fp29i_to_fp16;
    logic        clk = 1'b0;
    logic        rst, din_valid, din_uni_y_sgn, clr_flags;
    logic [5:0]  din_uni_y_exp;
    logic [21:0] din_uni_y_man_dn;
    logic        dout_valid, dout_ovf, dout_unf, dout_inx, flg_ovf, flg_unf, flg_inx;
    logic [15:0] dout_fp16;

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        logic        s;
        logic [5:0]  e;
        logic [21:0] m;
        logic [15:0] fp;
        logic [2:0]  f;   // {ovf, unf, inx}
    } vec_t;

    fp29i_to_fp16 dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_uni_y_sgn(din_uni_y_sgn),
        .din_uni_y_exp(din_uni_y_exp), .din_uni_y_man_dn(din_uni_y_man_dn),
        .clr_flags(clr_flags), .dout_valid(dout_valid), .dout_fp16(dout_fp16),
        .dout_ovf(dout_ovf), .dout_unf(dout_unf), .dout_inx(dout_inx),
        .flg_ovf(flg_ovf), .flg_unf(flg_unf), .flg_inx(flg_inx)
    );

    always #5 clk = ~clk;

    // Called #1 after a posedge; returns #1 after the posedge where the result appears.
    task automatic send_one(input logic s, input logic [5:0] e, input logic [21:0] m);
        din_valid = 1'b1; din_uni_y_sgn = s; din_uni_y_exp = e; din_uni_y_man_dn = m;
        @(posedge clk); #1; din_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_valid = 1'b0; clr_flags = 1'b0;
        din_uni_y_sgn = 1'b0; din_uni_y_exp = '0; din_uni_y_man_dn = '0;
        repeat (3) @(posedge clk);
        #1;
        ncmp++;
        if ({dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx} !== 20'h0) begin
            nerr++;
            $display("FAIL reset_out: got v=%b fp=%h f=%b%b%b want all 0",
                     dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx);
        end
        ncmp++;
        if ({flg_ovf, flg_unf, flg_inx} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_flg: got %b%b%b want 000", flg_ovf, flg_unf, flg_inx);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        din_valid = 1'b1; din_uni_y_sgn = 1'b0; din_uni_y_exp = 6'd30; din_uni_y_man_dn = 22'h100000;
        @(posedge clk); #1; din_valid = 1'b0;
        @(posedge clk); #1;
        ncmp++;
        if (dout_valid !== 1'b0) begin
            nerr++; $display("FAIL basic_early: got v=%b want 0", dout_valid);
        end
        @(posedge clk); #1;
        ncmp++;
        if ({dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx} !== {1'b1, 16'h3C00, 3'b000}) begin
            nerr++;
            $display("FAIL basic: got v=%b fp=%h f=%b%b%b want v=1 fp=3c00 f=000",
                     dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx);
        end
        @(posedge clk); #1;
        ncmp++;
        if (dout_valid !== 1'b0) begin
            nerr++; $display("FAIL basic_single: got v=%b want 0", dout_valid);
        end
    endtask

    task automatic test_round();
        vec_t tbl[$];
        tbl.push_back('{1'b0, 6'd30, 22'h100200, 16'h3C00, 3'b001}); // tie, even -> stays
        tbl.push_back('{1'b0, 6'd30, 22'h100600, 16'h3C02, 3'b001}); // tie, odd -> up
        tbl.push_back('{1'b0, 6'd30, 22'h100201, 16'h3C01, 3'b001}); // above half -> up
        tbl.push_back('{1'b0, 6'd30, 22'h1FFFFF, 16'h4000, 3'b001}); // frac carry into exp
        tbl.push_back('{1'b1, 6'd30, 22'h300000, 16'hC200, 3'b000}); // -3.0, L=0
        tbl.push_back('{1'b0, 6'd30, 22'h000001, 16'h0010, 3'b000}); // 2^-20, exact subnormal
        foreach (tbl[i]) begin
            send_one(tbl[i].s, tbl[i].e, tbl[i].m);
            ncmp++;
            if ({dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx} !== {1'b1, tbl[i].fp, tbl[i].f}) begin
                nerr++;
                $display("FAIL round[%0d]: got v=%b fp=%h f=%b%b%b want v=1 fp=%h f=%b",
                         i, dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx, tbl[i].fp, tbl[i].f);
            end
        end
    endtask

    task automatic test_subnormal();
        vec_t tbl[$];
        tbl.push_back('{1'b0, 6'd15, 22'h100000, 16'h0200, 3'b000}); // 2^-15
        tbl.push_back('{1'b0, 6'd14, 22'h100000, 16'h0100, 3'b000}); // 2^-16
        tbl.push_back('{1'b0, 6'd6,  22'h100000, 16'h0001, 3'b000}); // min subnormal
        tbl.push_back('{1'b0, 6'd5,  22'h100000, 16'h0000, 3'b011}); // half min, tie to 0
        tbl.push_back('{1'b0, 6'd0,  22'h000001, 16'h0000, 3'b011}); // shift saturates
        tbl.push_back('{1'b1, 6'd0,  22'h000001, 16'h8000, 3'b011});
        tbl.push_back('{1'b0, 6'd15, 22'h1FFFFF, 16'h0400, 3'b011}); // rounds to min normal
        foreach (tbl[i]) begin
            send_one(tbl[i].s, tbl[i].e, tbl[i].m);
            ncmp++;
            if ({dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx} !== {1'b1, tbl[i].fp, tbl[i].f}) begin
                nerr++;
                $display("FAIL subn[%0d]: got v=%b fp=%h f=%b%b%b want v=1 fp=%h f=%b",
                         i, dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx, tbl[i].fp, tbl[i].f);
            end
        end
    endtask

    task automatic test_zero();
        send_one(1'b0, 6'd63, 22'h0);
        ncmp++;
        if ({dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx} !== {1'b1, 16'h0000, 3'b000}) begin
            nerr++;
            $display("FAIL zero_pos: got v=%b fp=%h f=%b%b%b want v=1 fp=0000 f=000",
                     dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx);
        end
        send_one(1'b1, 6'd30, 22'h0);
        ncmp++;
        if ({dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx} !== {1'b1, 16'h8000, 3'b000}) begin
            nerr++;
            $display("FAIL zero_neg: got v=%b fp=%h f=%b%b%b want v=1 fp=8000 f=000",
                     dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx);
        end
        repeat (2) @(posedge clk);
        #1;
        ncmp++;
        if ({dout_valid, dout_fp16} !== {1'b0, 16'h8000}) begin
            nerr++; $display("FAIL hold: got v=%b fp=%h want v=0 fp=8000", dout_valid, dout_fp16);
        end
    endtask

    task automatic test_overflow_sticky();
        vec_t tbl[$];
        ncmp++;
        if ({flg_ovf, flg_unf, flg_inx} !== 3'b011) begin
            nerr++; $display("FAIL flg_before: got %b%b%b want 011", flg_ovf, flg_unf, flg_inx);
        end
        clr_flags = 1'b1; @(posedge clk); #1; clr_flags = 1'b0;
        ncmp++;
        if ({flg_ovf, flg_unf, flg_inx} !== 3'b000) begin
            nerr++; $display("FAIL flg_clr0: got %b%b%b want 000", flg_ovf, flg_unf, flg_inx);
        end
        tbl.push_back('{1'b0, 6'd45, 22'h100000, 16'h7800, 3'b000}); // E=30 exact
        tbl.push_back('{1'b0, 6'd45, 22'h1FFC00, 16'h7BFF, 3'b000}); // max finite
        tbl.push_back('{1'b0, 6'd45, 22'h1FFFFF, 16'h7C00, 3'b101}); // overflows by rounding
        tbl.push_back('{1'b0, 6'd46, 22'h100000, 16'h7C00, 3'b101}); // E=31
        tbl.push_back('{1'b1, 6'd63, 22'h100000, 16'hFC00, 3'b101});
        tbl.push_back('{1'b0, 6'd63, 22'h100000, 16'h7C00, 3'b101});
        foreach (tbl[i]) begin
            send_one(tbl[i].s, tbl[i].e, tbl[i].m);
            ncmp++;
            if ({dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx} !== {1'b1, tbl[i].fp, tbl[i].f}) begin
                nerr++;
                $display("FAIL ovf[%0d]: got v=%b fp=%h f=%b%b%b want v=1 fp=%h f=%b",
                         i, dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx, tbl[i].fp, tbl[i].f);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        ncmp++;
        if ({flg_ovf, flg_unf, flg_inx} !== 3'b101) begin
            nerr++; $display("FAIL flg_held: got %b%b%b want 101", flg_ovf, flg_unf, flg_inx);
        end
        clr_flags = 1'b1; @(posedge clk); #1; clr_flags = 1'b0;
        ncmp++;
        if ({flg_ovf, flg_unf, flg_inx} !== 3'b000) begin
            nerr++; $display("FAIL flg_clr1: got %b%b%b want 000", flg_ovf, flg_unf, flg_inx);
        end
    endtask

    task automatic test_clr_collision();
        send_one(1'b0, 6'd63, 22'h100000);
        clr_flags = 1'b1;
        @(posedge clk); #1; clr_flags = 1'b0;
        ncmp++;
        if ({flg_ovf, flg_unf, flg_inx} !== 3'b101) begin
            nerr++; $display("FAIL clr_vs_set: got %b%b%b want 101", flg_ovf, flg_unf, flg_inx);
        end
        clr_flags = 1'b1; @(posedge clk); #1; clr_flags = 1'b0;
        ncmp++;
        if (flg_ovf !== 1'b0) begin
            nerr++; $display("FAIL clr_after: got %b want 0", flg_ovf);
        end
    endtask

    task automatic test_back_to_back_reset();
        int seen = 0;
        din_valid = 1'b1; din_uni_y_sgn = 1'b0; din_uni_y_exp = 6'd30; din_uni_y_man_dn = 22'h100000;
        @(posedge clk); #1; din_uni_y_exp = 6'd63;
        @(posedge clk); #1; din_uni_y_exp = 6'd15; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; din_valid = 1'b0;
        ncmp++;
        if ({dout_fp16, flg_ovf, flg_unf, flg_inx} !== 19'h0) begin
            nerr++; $display("FAIL rst_mid: got fp=%h flg=%b%b%b want 0", dout_fp16, flg_ovf, flg_unf, flg_inx);
        end
        for (int c = 0; c < 6; c++) begin
            if (dout_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        ncmp++;
        if (seen !== 0) begin
            nerr++; $display("FAIL rst_drop: got %0d valid outputs want 0", seen);
        end
        send_one(1'b0, 6'd30, 22'h100600);
        ncmp++;
        if ({dout_valid, dout_fp16} !== {1'b1, 16'h3C02}) begin
            nerr++; $display("FAIL rst_resume: got v=%b fp=%h want v=1 fp=3c02", dout_valid, dout_fp16);
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_basic();
        test_round();
        test_subnormal();
        test_zero();
        test_overflow_sticky();
        test_clr_collision();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
